// File: rtl/ysyx_22050078_isram_if.sv
// Instruction-fetch bus between the fetch unit (master), the instruction
// responder (slave) and the physical-memory read port (mem).
//
// Handshake rule for both the AR and the R channel: a transfer happens on a
// rising clock edge where valid and ready are both high. Once valid is raised,
// the sender holds valid and its payload stable until that edge. Ready may
// depend combinationally on state, but never on valid in the same cycle.
//
// Signals
//   ar_valid/ar_ready/ar_addr  fetch request channel
//   r_valid/r_ready/r_data/r_resp  response channel (resp 00 OK, 10 misaligned, 11 out of range)
//   busy                       request outstanding
//   pmem_ren/pmem_addr         one-cycle physical-memory read strobe and address
//   pmem_rdata                 64-bit read data returned combinationally by memory
//   dbg_state                  responder FSM state (0 IDLE, 1 WAIT, 2 RESP)
interface ysyx_22050078_isram_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
);
  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              busy;
  logic              pmem_ren;
  logic [ADDR_W-1:0] pmem_addr;
  logic [63:0]       pmem_rdata;
  logic [1:0]        dbg_state;

  modport master (
    output ar_valid, ar_addr, r_ready,
    input  ar_ready, r_valid, r_data, r_resp, busy, dbg_state
  );

  modport slave (
    input  ar_valid, ar_addr, r_ready, pmem_rdata,
    output ar_ready, r_valid, r_data, r_resp, busy, pmem_ren, pmem_addr, dbg_state
  );

  modport mem (
    input  pmem_ren, pmem_addr,
    output pmem_rdata
  );
endinterface

// File: rtl/ysyx_22050078_isram.sv
// Instruction-memory responder. Accepts one fetch address on AR, waits
// LATENCY cycles, classifies the address, performs a single physical-memory
// read for legal addresses and returns the instruction word on R.
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   ysyx_22050078_isram_if.slave (AR, R, busy, pmem read port, dbg_state)
//
// Parameters
//   ADDR_W, DATA_W       address / instruction widths
//   LATENCY              cycles from AR accept edge to r_valid (1..15)
//   PMEM_BASE, PMEM_SIZE legal fetch window in bytes
module ysyx_22050078_isram #(
  parameter int                 ADDR_W    = 64,
  parameter int                 DATA_W    = 32,
  parameter int                 LATENCY   = 1,
  parameter logic [ADDR_W-1:0]  PMEM_BASE = 64'h0000_0000_8000_0000,
  parameter logic [ADDR_W-1:0]  PMEM_SIZE = 64'h0000_0000_0800_0000
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_22050078_isram_if.slave     bus
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
    $error("ysyx_22050078_isram: LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;

  logic              w_ar_fire;
  logic              w_r_fire;
  logic              w_due;
  logic              w_misaligned;
  logic              w_out_of_range;
  logic              w_read;
  logic [ADDR_W:0]   w_addr_x;
  logic [ADDR_W:0]   w_lo;
  logic [ADDR_W:0]   w_hi;
  logic              w_unused_pmem_hi;

  // Range limits carry one extra bit so BASE+SIZE never wraps.
  assign w_addr_x       = {1'b0, r_addr};
  assign w_lo           = {1'b0, PMEM_BASE};
  assign w_hi           = {1'b0, PMEM_BASE} + {1'b0, PMEM_SIZE} - (ADDR_W+1)'(4);
  assign w_misaligned   = (r_addr[1:0] != 2'b00);
  assign w_out_of_range = (w_addr_x < w_lo) || (w_addr_x > w_hi);

  assign w_ar_fire = bus.ar_valid & bus.ar_ready;
  assign w_r_fire  = r_valid & bus.r_ready;
  assign w_due     = (r_state == ST_WAIT) && (r_cnt == 4'd0);

  // The memory read is issued only in the final WAIT cycle of a legal address,
  // so misaligned/out-of-range fetches never touch memory.
  assign w_read = w_due & ~w_misaligned & ~w_out_of_range & ~rst;

  assign bus.ar_ready  = (r_state == ST_IDLE) & ~rst;
  assign bus.busy      = (r_state != ST_IDLE) & ~rst;
  assign bus.r_valid   = r_valid;
  assign bus.r_data    = r_data;
  assign bus.r_resp    = r_resp;
  assign bus.pmem_ren  = w_read;
  assign bus.pmem_addr = r_addr;
  assign bus.dbg_state = r_state;

  assign w_unused_pmem_hi = ^bus.pmem_rdata[63:DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_resp  <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ar_fire) begin
            r_addr  <= bus.ar_addr;
            r_cnt   <= LAT_M1;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= ST_RESP;
            r_valid <= 1'b1;
            // Misalignment is reported ahead of the range error.
            if (w_misaligned) begin
              r_resp <= 2'b10;
              r_data <= '0;
            end else if (w_out_of_range) begin
              r_resp <= 2'b11;
              r_data <= '0;
            end else begin
              r_resp <= 2'b00;
              r_data <= bus.pmem_rdata[DATA_W-1:0];
            end
          end
        end
        ST_RESP: begin
          if (w_r_fire) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050078_isram.sv
module tb_ysyx_22050078_isram;
  localparam int          LAT  = 3;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam logic [63:0] SIZE = 64'h0000_0000_0800_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_22050078_isram_if #(.ADDR_W(64), .DATA_W(32)) bus();

  ysyx_22050078_isram #(
    .ADDR_W(64), .DATA_W(32), .LATENCY(LAT), .PMEM_BASE(BASE), .PMEM_SIZE(SIZE)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- pmem model ----------------
  logic [31:0] mem [0:63];

  function automatic logic [31:0] pmem_word(input logic [63:0] a);
    logic [63:0] off;
    int idx;
    if (a >= BASE && a < BASE + 64'd256) begin
      off = (a - BASE) >> 2;
      idx = int'(off);
      return mem[idx];
    end
    return a[31:0] ^ 32'h5A5A_1234;
  endfunction

  assign bus.pmem_rdata = {32'hDEAD_BEEF, pmem_word(bus.pmem_addr)};

  // Expected response {resp, data} from the address rules alone.
  function automatic logic [33:0] model_resp(input logic [63:0] a);
    logic [64:0] ax, lo, hi;
    ax = {1'b0, a};
    lo = {1'b0, BASE};
    hi = {1'b0, BASE} + {1'b0, SIZE} - 65'd4;
    if (a[1:0] != 2'b00) return {2'b10, 32'h0};
    if (ax < lo || ax > hi) return {2'b11, 32'h0};
    return {2'b00, pmem_word(a)};
  endfunction

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [33:0] exp_q[$];
  int          cyc = 0;
  bit          m_out = 0;
  int          m_due = 0;
  bit          m_ok = 0;
  logic [63:0] m_addr = '0;
  int          m_calls = 0;
  int          act_calls = 0;

  // Model: one request in flight; response due LAT edges after the AR accept.
  always @(posedge clk or posedge rst) begin
    bit rv;
    logic [33:0] e;
    if (rst) begin
      m_out = 0;
      exp_q.delete();
    end else begin
      rv = m_out && (cyc >= m_due);
      cyc++;
      if (rv && bus.r_ready) begin
        void'(exp_q.pop_front());
        m_out = 0;
      end else if (!m_out && bus.ar_valid) begin
        m_out  = 1;
        m_due  = cyc + LAT;
        m_addr = bus.ar_addr;
        e      = model_resp(bus.ar_addr);
        m_ok   = (e[33:32] == 2'b00);
        exp_q.push_back(e);
      end
      if (m_out && cyc == m_due && m_ok) m_calls++;
    end
  end

  always @(posedge clk) begin
    if (!rst && bus.pmem_ren) act_calls++;
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic erv, ear, ebusy, eren;
    erv   = !rst && m_out && (cyc >= m_due);
    ear   = !rst && !m_out;
    ebusy = !rst && m_out;
    eren  = !rst && m_out && (cyc == m_due - 1) && m_ok;
    chk("ar_ready", bus.ar_ready, ear);
    chk("r_valid",  bus.r_valid,  erv);
    chk("busy",     bus.busy,     ebusy);
    chk("pmem_ren", bus.pmem_ren, eren);
    if (eren && bus.pmem_ren) chk("pmem_addr", bus.pmem_addr, m_addr);
    if (erv && bus.r_valid && exp_q.size() > 0)
      chk("r_beat", {30'h0, bus.r_resp, bus.r_data}, {30'h0, exp_q[0]});
  end

  // ---------------- driver tasks ----------------
  task automatic fetch(input logic [63:0] addr, input int smin, input int smax,
                       output logic [31:0] d, output logic [1:0] rsp);
    bit got;
    int n;
    d = '0;
    rsp = '0;
    got = 0;
    bus.ar_valid = 1'b1;
    bus.ar_addr  = addr;
    for (int t = 0; t < 20 && !got; t++) begin
      got = bus.ar_ready;
      @(posedge clk);
    end
    #1;
    bus.ar_valid = 1'b0;
    bus.ar_addr  = {$urandom, $urandom};
    chk("ar_handshake", got, 1);
    if (!got) return;
    got = 0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      got = bus.r_valid;
    end
    chk("r_arrival", got, 1);
    if (!got) return;
    n = $urandom_range(smin, smax);
    repeat (n) @(negedge clk);
    d   = bus.r_data;
    rsp = bus.r_resp;
    #1 bus.r_ready = 1'b1;
    @(posedge clk);
    #1 bus.r_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] d;
  logic [1:0]  rsp;
  logic [63:0] a;
  logic [33:0] e;
  int          calls0;
  bit          got;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0413;
    bus.ar_valid = 1'b0;
    bus.ar_addr  = '0;
    bus.r_ready  = 1'b0;

    // 1: reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_r_data", bus.r_data, 0);
    chk("rst_r_resp", bus.r_resp, 0);
    chk("rst_state", bus.dbg_state, 0);
    chk("rst_ar_ready", bus.ar_ready, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ar_ready", bus.ar_ready, 1);
    #1;

    // 2: first fetch, no stall
    fetch(BASE, 0, 0, d, rsp);
    chk("t2_data", d, 32'h0000_0413);
    chk("t2_resp", rsp, 2'b00);
    @(negedge clk);
    chk("t2_ar_ready_after", bus.ar_ready, 1);
    #1;

    // 3: held response for 5 cycles, exactly one read
    calls0 = act_calls;
    fetch(BASE + 64'd12, 5, 5, d, rsp);
    chk("t3_data", d, mem[3]);
    chk("t3_calls", act_calls - calls0, 1);

    // 4: misaligned and below-range, no reads
    calls0 = act_calls;
    fetch(64'h8000_0002, 0, 1, d, rsp);
    chk("t4_mis_resp", rsp, 2'b10);
    chk("t4_mis_data", d, 0);
    fetch(64'h7FFF_FFFC, 0, 1, d, rsp);
    chk("t4_low_resp", rsp, 2'b11);
    chk("t4_low_data", d, 0);
    chk("t4_calls", act_calls - calls0, 0);
    // window edges
    fetch(64'h87FF_FFFC, 0, 0, d, rsp);
    chk("top_resp", rsp, 2'b00);
    chk("top_data", d, 32'hDDA5_EDC8);
    fetch(64'h8800_0000, 0, 0, d, rsp);
    chk("above_resp", rsp, 2'b11);
    fetch(64'hFFFF_FFFF_FFFF_FFFC, 0, 0, d, rsp);
    chk("wrap_resp", rsp, 2'b11);
    fetch(64'h8800_0001, 0, 0, d, rsp);
    chk("prio_resp", rsp, 2'b10);

    // 5: async reset mid-request
    @(negedge clk);
    #1;
    calls0 = act_calls;
    bus.ar_valid = 1'b1;
    bus.ar_addr  = BASE + 64'd8;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      got = bus.ar_ready;
      @(posedge clk);
    end
    #1 bus.ar_valid = 1'b0;
    chk("t5_handshake", got, 1);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_r_valid", bus.r_valid, 0);
    chk("t5_r_data", bus.r_data, 0);
    #1 rst = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    chk("t5_no_resp", bus.r_valid, 0);
    chk("t5_calls", act_calls - calls0, 0);
    #1;
    fetch(BASE + 64'd4, 0, 2, d, rsp);
    chk("t5_refetch", d, mem[1]);
    chk("t5_refetch_resp", rsp, 2'b00);

    // 6: in-order sequence with random stalls
    calls0 = act_calls;
    for (int i = 0; i < 16; i++) begin
      a = BASE + 64'(4 * i);
      fetch(a, 0, 3, d, rsp);
      chk("t6_data", d, mem[i]);
    end
    chk("t6_calls", act_calls - calls0, 16);

    // random mix of legal, misaligned and out-of-range addresses
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: a = BASE + 64'({$urandom_range(0, 63), 2'b00});
        1: a = BASE + 64'($urandom_range(0, 255));
        2: a = BASE - 64'({$urandom_range(1, 1000), 2'b00});
        3: a = BASE + SIZE + 64'({$urandom_range(0, 3), 2'b00}) - 64'd8;
        default: a = {$urandom, $urandom};
      endcase
      fetch(a, 0, 3, d, rsp);
      e = model_resp(a);
      chk("rand_beat", {30'h0, rsp, d}, {30'h0, e});
    end

    repeat (3) @(negedge clk);
    chk("dpi_total", act_calls, m_calls);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
